hazard_sequencer: RTL and testbench
===================================

HAZARD_SEQUENCER -- requirements
Module: hazard_sequencer

Interface
REQ-001 The block SHALL have parameter REG_INDEX_BIT_WIDTH, default 4, meaning the register-number width.
REQ-002 The block SHALL have parameter IO_TIMEOUT, default 8'd255, meaning the maximum IO_WAIT cycles before forced release.
REQ-003 The block SHALL have parameter CNT_BITS, default 16, meaning the performance-counter width.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset, on these ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- if_rs1, if_rs2  in  REG_INDEX_BIT_WIDTH each  source registers of the instruction in IF
- if_uses_rs1, if_uses_rs2  in  1 each  the IF instruction reads the corresponding source register
- dec_is_load  in  1  the instruction in DEC is a load
- dec_rd  in  REG_INDEX_BIT_WIDTH  destination register of the instruction in DEC
- mispredict  in  1  the branch handler reports a wrong prediction this cycle
- ex_io_req  in  1  the EX/ME instruction accesses memory-mapped I/O
- ex_io_ack  in  1  the I/O access completes this cycle
- pc_wrt_en, if_wrt_en, dec_wrt_en, ex_wrt_en  out  1 each  pipeline-register load enables
- if_flush, dec_flush  out  1 each  load a bubble instead of data
- io_timeout  out  1  sticky flag: an I/O wait was forcibly released
- stall_cycles, flush_count  out  CNT_BITS each  saturating performance counters
- state  out  2  current state, for debug

Function
REQ-005 The FSM SHALL have states DRAIN=2'd0, RUN=2'd1, IO_WAIT=2'd2; state 2'd3 SHALL go to RUN.
REQ-006 Pipeline controls SHALL be combinational from state and same-cycle inputs (zero latency); state and counters SHALL be registered.
REQ-007 DRAIN: pc_wrt_en=0, if_flush=1, dec_flush=1, other enables 1; next state RUN unconditionally (exactly one cycle).
REQ-008 RUN priority 1, mispredict=1: all enables 1, if_flush=1, dec_flush=1; stay in RUN; flush_count increments.
REQ-009 RUN priority 2, ex_io_req=1 and ex_io_ack=0: all four enables 0, no flush; wait counter loads 1; next state IO_WAIT.
REQ-010 RUN priority 3, load-use: holds when dec_is_load=1, dec_rd!=0, and (if_uses_rs1 and if_rs1==dec_rd, or if_uses_rs2 and if_rs2==dec_rd).
- Response: pc_wrt_en=0, if_wrt_en=0, dec_wrt_en=1, dec_flush=1, ex_wrt_en=1; stay in RUN.
REQ-011 Register 0 SHALL never cause a load-use stall.
REQ-012 RUN with none of the above: all enables 1, no flush.
REQ-013 In RUN, ex_io_req=1 together with ex_io_ack=1 SHALL NOT stall.
REQ-014 IO_WAIT, ex_io_ack=1: all enables 1; next state RUN.
REQ-015 IO_WAIT, ex_io_ack=0 and wait counter==IO_TIMEOUT: all enables 1; io_timeout sets; next state RUN.
REQ-016 IO_WAIT otherwise: all enables 0; wait counter increments (8-bit, never wraps before timeout).
REQ-017 mispredict and load-use SHALL be ignored in IO_WAIT and DRAIN, because the frozen pipeline keeps them stable.
REQ-018 stall_cycles SHALL increment on every cycle with pc_wrt_en=0 in RUN or IO_WAIT, and never in DRAIN.
REQ-019 Both counters SHALL saturate at all-ones and never wrap.
REQ-020 io_timeout SHALL remain set until reset.

Reset
REQ-021 Reset SHALL act on the next clk edge and take priority over all inputs.
REQ-022 After reset: state=DRAIN, wait counter=0, io_timeout=0, stall_cycles=0, flush_count=0.
REQ-023 Reset asserted in any state, including mid-IO_WAIT, SHALL abandon the wait and enter DRAIN.
REQ-024 While reset is high, outputs SHALL take the DRAIN values.

Structure
REQ-025 Package hazard_pkg SHALL hold the state encoding constants, the CNT_BITS default, and the IO_TIMEOUT default.
REQ-026 One sub-module, sat_counter (parameter width, inputs clk/reset/inc, output count), SHALL be instantiated twice, for stall_cycles and flush_count.
REQ-027 Load-use comparison and output decode SHALL live in the top module.

Verification
REQ-028 The bench SHALL cover these directed scenarios:
- Reset then release -> one DRAIN cycle with pc_wrt_en=0, if_flush=1, dec_flush=1; then state=RUN, all enables 1, counters 0.
- dec_is_load=1, dec_rd=5, if_rs2=5, if_uses_rs2=1 for one cycle -> pc_wrt_en=0, if_wrt_en=0, dec_flush=1; stall_cycles=1. Repeat with dec_rd=0 -> no stall.
- mispredict=1 together with the load-use condition -> flush wins, enables 1; flush_count=1, stall_cycles unchanged.
- ex_io_req=1, ex_io_ack low for 3 cycles then high -> enables 0 for 3 cycles, released on the ack cycle; stall_cycles=3; io_timeout=0.
- ex_io_req=1, ack never asserted -> release after IO_TIMEOUT wait cycles; io_timeout=1 and stays 1; reset mid-wait on a second run -> DRAIN.
- Force 70000 stall cycles -> stall_cycles holds 16'hFFFF.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard sequencer: FSM state encoding and the
// default values of the performance-counter width and I/O wait limit.
package hazard_pkg;

  typedef enum logic [1:0] {
    ST_DRAIN   = 2'd0,
    ST_RUN     = 2'd1,
    ST_IO_WAIT = 2'd2,
    ST_RSVD    = 2'd3
  } state_e;

  localparam int unsigned CNT_BITS_DEF   = 16;
  localparam logic [7:0]  IO_TIMEOUT_DEF = 8'd255;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts cycles with inc=1, sticks at all-ones.
// Ports: clk, reset (sync, active high), inc, count[WIDTH-1:0].
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_sequencer.sv
// Pipeline hazard sequencer. Decodes per-cycle stage enables/flushes from the
// FSM state and same-cycle hazard inputs (load-use, mispredict, I/O waits).
// Ports: clk/reset; IF source regs + use flags; DEC load flag + rd;
// mispredict; ex_io_req/ex_io_ack; stage write enables and flushes;
// sticky io_timeout; saturating stall_cycles/flush_count; debug state.
module hazard_sequencer
  import hazard_pkg::*;
#(
  parameter int unsigned REG_INDEX_BIT_WIDTH = 4,
  parameter logic [7:0]  IO_TIMEOUT          = IO_TIMEOUT_DEF,
  parameter int unsigned CNT_BITS            = CNT_BITS_DEF
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] if_rs1,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] if_rs2,
  input  logic                           if_uses_rs1,
  input  logic                           if_uses_rs2,
  input  logic                           dec_is_load,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] dec_rd,
  input  logic                           mispredict,
  input  logic                           ex_io_req,
  input  logic                           ex_io_ack,
  output logic                           pc_wrt_en,
  output logic                           if_wrt_en,
  output logic                           dec_wrt_en,
  output logic                           ex_wrt_en,
  output logic                           if_flush,
  output logic                           dec_flush,
  output logic                           io_timeout,
  output logic [CNT_BITS-1:0]            stall_cycles,
  output logic [CNT_BITS-1:0]            flush_count,
  output logic [1:0]                     state
);

  state_e     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic       io_timeout_q, io_timeout_d;
  logic       load_use, stall_inc, flush_inc;

  // r0 is hardwired zero, so a load targeting it never creates a dependency.
  assign load_use = dec_is_load && (dec_rd != '0) &&
                    ((if_uses_rs1 && (if_rs1 == dec_rd)) ||
                     (if_uses_rs2 && (if_rs2 == dec_rd)));

  always_comb begin
    pc_wrt_en    = 1'b1;
    if_wrt_en    = 1'b1;
    dec_wrt_en   = 1'b1;
    ex_wrt_en    = 1'b1;
    if_flush     = 1'b0;
    dec_flush    = 1'b0;
    state_d      = state_q;
    wait_d       = wait_q;
    io_timeout_d = io_timeout_q;
    flush_inc    = 1'b0;
    if (reset) begin
      // Present DRAIN controls while reset is held; the flops clear themselves.
      pc_wrt_en = 1'b0;
      if_flush  = 1'b1;
      dec_flush = 1'b1;
    end else begin
      unique case (state_q)
        ST_DRAIN: begin
          pc_wrt_en = 1'b0;
          if_flush  = 1'b1;
          dec_flush = 1'b1;
          state_d   = ST_RUN;
        end
        ST_RUN: begin
          if (mispredict) begin
            if_flush  = 1'b1;
            dec_flush = 1'b1;
            flush_inc = 1'b1;
          end else if (ex_io_req && !ex_io_ack) begin
            pc_wrt_en  = 1'b0;
            if_wrt_en  = 1'b0;
            dec_wrt_en = 1'b0;
            ex_wrt_en  = 1'b0;
            wait_d     = 8'd1;
            state_d    = ST_IO_WAIT;
          end else if (load_use) begin
            // Hold PC/IF, let the load advance, bubble into DEC.
            pc_wrt_en = 1'b0;
            if_wrt_en = 1'b0;
            dec_flush = 1'b1;
          end
        end
        ST_IO_WAIT: begin
          if (ex_io_ack) begin
            state_d = ST_RUN;
          end else if (wait_q == IO_TIMEOUT) begin
            io_timeout_d = 1'b1;
            state_d      = ST_RUN;
          end else begin
            pc_wrt_en  = 1'b0;
            if_wrt_en  = 1'b0;
            dec_wrt_en = 1'b0;
            ex_wrt_en  = 1'b0;
            wait_d     = wait_q + 8'd1;
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
    // DRAIN also holds the PC but is not a hazard stall.
    stall_inc = !reset && !pc_wrt_en &&
                ((state_q == ST_RUN) || (state_q == ST_IO_WAIT));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_DRAIN;
      wait_q       <= 8'd0;
      io_timeout_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      io_timeout_q <= io_timeout_d;
    end
  end

  sat_counter #(.WIDTH(CNT_BITS)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_inc),
    .count (stall_cycles)
  );

  sat_counter #(.WIDTH(CNT_BITS)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush_inc),
    .count (flush_count)
  );

  assign io_timeout = io_timeout_q;
  assign state      = state_q;

endmodule

// File: tb/tb_hazard_sequencer.sv
module tb_hazard_sequencer;

  // {pc, if, dec, ex, if_flush, dec_flush}
  typedef logic [5:0] ctl_t;
  localparam ctl_t CTL_RUN    = 6'b111100;
  localparam ctl_t CTL_DRAIN  = 6'b011111;
  localparam ctl_t CTL_FREEZE = 6'b000000;
  localparam ctl_t CTL_LU     = 6'b001101;
  localparam ctl_t CTL_FLUSH  = 6'b111111;

  typedef struct {
    logic [3:0] rs1, rs2, rd;
    logic       u1, u2, ld, mp, req, ack;
    ctl_t       exp;
  } vec_t;

  logic        clk = 1'b0, reset = 1'b1;
  logic [3:0]  if_rs1 = '0, if_rs2 = '0, dec_rd = '0;
  logic        if_uses_rs1 = 0, if_uses_rs2 = 0, dec_is_load = 0;
  logic        mispredict = 0, ex_io_req = 0, ex_io_ack = 0;
  logic        pc_wrt_en, if_wrt_en, dec_wrt_en, ex_wrt_en, if_flush, dec_flush;
  logic        io_timeout;
  logic [15:0] stall_cycles, flush_count;
  logic [1:0]  state;

  int   vectors = 0, miscompares = 0;
  int   stall_exp = 0, flush_exp = 0;
  ctl_t exp_q[$];
  vec_t tbl[12];

  hazard_sequencer dut (
    .clk(clk), .reset(reset), .if_rs1(if_rs1), .if_rs2(if_rs2),
    .if_uses_rs1(if_uses_rs1), .if_uses_rs2(if_uses_rs2),
    .dec_is_load(dec_is_load), .dec_rd(dec_rd), .mispredict(mispredict),
    .ex_io_req(ex_io_req), .ex_io_ack(ex_io_ack),
    .pc_wrt_en(pc_wrt_en), .if_wrt_en(if_wrt_en), .dec_wrt_en(dec_wrt_en),
    .ex_wrt_en(ex_wrt_en), .if_flush(if_flush), .dec_flush(dec_flush),
    .io_timeout(io_timeout), .stall_cycles(stall_cycles),
    .flush_count(flush_count), .state(state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    if_rs1 = v.rs1; if_rs2 = v.rs2; dec_rd = v.rd;
    if_uses_rs1 = v.u1; if_uses_rs2 = v.u2; dec_is_load = v.ld;
    mispredict = v.mp; ex_io_req = v.req; ex_io_ack = v.ack;
    exp_q.push_back(v.exp);
  endtask

  // Expect a control pattern for the stimulus currently applied.
  task automatic expect_ctl(input ctl_t e);
    exp_q.push_back(e);
  endtask

  task automatic sample(input string nm);
    ctl_t got, e;
    @(negedge clk);
    got = {pc_wrt_en, if_wrt_en, dec_wrt_en, ex_wrt_en, if_flush, dec_flush};
    if (exp_q.size() == 0) begin
      chk({nm, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk(nm, 32'(got), 32'(e));
    end
  endtask

  function automatic vec_t mk(input logic [3:0] rs1, rs2, rd,
                              input logic u1, u2, ld, mp, req, ack,
                              input ctl_t e);
    vec_t v;
    v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.u1 = u1; v.u2 = u2; v.ld = ld;
    v.mp = mp; v.req = req; v.ack = ack; v.exp = e;
    return v;
  endfunction

  initial begin
    vec_t idle;
    int   cnt;
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, CTL_RUN);
    //            rs1 rs2 rd u1 u2 ld mp rq ak
    tbl[0]  = mk(0,  0,  0, 0, 0, 0, 0, 0, 0, CTL_RUN);    // idle
    tbl[1]  = mk(0,  5,  5, 0, 1, 1, 0, 0, 0, CTL_LU);     // rs2 load-use
    tbl[2]  = mk(0,  0,  0, 0, 1, 1, 0, 0, 0, CTL_RUN);    // r0 never stalls
    tbl[3]  = mk(7,  1,  7, 1, 0, 1, 0, 0, 0, CTL_LU);     // rs1 load-use
    tbl[4]  = mk(7,  1,  7, 0, 0, 1, 0, 0, 0, CTL_RUN);    // match, not used
    tbl[5]  = mk(7,  7,  7, 1, 1, 0, 0, 0, 0, CTL_RUN);    // not a load
    tbl[6]  = mk(0,  5,  5, 0, 1, 1, 1, 0, 0, CTL_FLUSH);  // flush beats load-use
    tbl[7]  = mk(0,  0,  0, 0, 0, 0, 0, 1, 1, CTL_RUN);    // req+ack same cycle
    tbl[8]  = mk(0,  0,  0, 0, 0, 0, 1, 0, 0, CTL_FLUSH);  // mispredict alone
    tbl[9]  = mk(2,  4,  3, 1, 1, 1, 0, 0, 0, CTL_RUN);    // no reg match
    tbl[10] = mk(0, 15, 15, 0, 1, 1, 0, 0, 0, CTL_LU);     // top register
    tbl[11] = mk(0,  0,  0, 0, 0, 0, 1, 1, 0, CTL_FLUSH);  // flush beats io stall

    // Reset and the single DRAIN cycle.
    tick(); tick();
    expect_ctl(CTL_DRAIN);
    sample("reset_held_ctl");
    chk("reset_state", 32'(state), 32'd0);
    tick();
    reset = 1'b0;
    expect_ctl(CTL_DRAIN);
    sample("drain_ctl");
    chk("drain_state", 32'(state), 32'd0);
    chk("rst_stall", 32'(stall_cycles), 32'd0);
    chk("rst_flush", 32'(flush_count), 32'd0);
    chk("rst_iot", 32'(io_timeout), 32'd0);
    tick();
    chk("run_state", 32'(state), 32'd1);
    chk("drain_no_stall", 32'(stall_cycles), 32'd0);

    // Single-cycle RUN vectors, counters checked after each edge.
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i]);
      sample($sformatf("vec%0d_ctl", i));
      if (tbl[i].exp[5] == 1'b0) stall_exp++;
      if (tbl[i].mp) flush_exp++;
      tick();
      chk($sformatf("vec%0d_state", i), 32'(state), 32'd1);
      chk($sformatf("vec%0d_stall", i), 32'(stall_cycles), 32'(stall_exp));
      chk($sformatf("vec%0d_flush", i), 32'(flush_count), 32'(flush_exp));
    end

    // I/O wait released by ack on the fourth cycle.
    drive(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, CTL_FREEZE));
    sample("io_c1");
    tick();
    chk("io_wait_state", 32'(state), 32'd2);
    expect_ctl(CTL_FREEZE); sample("io_c2"); tick();
    expect_ctl(CTL_FREEZE); sample("io_c3"); tick();
    ex_io_ack = 1'b1;
    expect_ctl(CTL_RUN); sample("io_ack_release");
    tick();
    drive(idle);
    sample("io_after");
    stall_exp += 3;
    chk("io_state_run", 32'(state), 32'd1);
    chk("io_stall", 32'(stall_cycles), 32'(stall_exp));
    chk("io_no_timeout", 32'(io_timeout), 32'd0);
    tick();

    // I/O wait with no ack: forced release after IO_TIMEOUT stalled cycles.
    ex_io_req = 1'b1; ex_io_ack = 1'b0;
    cnt = 0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (pc_wrt_en) break;
      cnt++;
      tick();
    end
    ex_io_req = 1'b0;
    chk("timeout_cycles", 32'(cnt), 32'd255);
    tick();
    stall_exp += 255;
    chk("timeout_flag", 32'(io_timeout), 32'd1);
    chk("timeout_state", 32'(state), 32'd1);
    chk("timeout_stall", 32'(stall_cycles), 32'(stall_exp));
    repeat (4) tick();
    chk("timeout_sticky", 32'(io_timeout), 32'd1);

    // Second wait abandoned by reset.
    ex_io_req = 1'b1;
    repeat (3) tick();
    chk("wait2_state", 32'(state), 32'd2);
    reset = 1'b1;
    expect_ctl(CTL_DRAIN);
    sample("reset_mid_wait_ctl");
    tick();
    chk("reset_mid_wait_state", 32'(state), 32'd0);
    chk("reset_clears_iot", 32'(io_timeout), 32'd0);
    chk("reset_clears_stall", 32'(stall_cycles), 32'd0);
    reset = 1'b0; ex_io_req = 1'b0;
    expect_ctl(CTL_DRAIN);
    sample("drain2_ctl");
    tick();
    chk("run2_state", 32'(state), 32'd1);

    // Saturation: hold a load-use hazard for 70000 cycles.
    drive(mk(5, 0, 5, 1, 0, 1, 0, 0, 0, CTL_LU));
    sample("sat_ctl");
    repeat (70000) tick();
    chk("stall_saturated", 32'(stall_cycles), 32'h0000FFFF);
    drive(idle);
    sample("sat_release");
    tick();
    chk("stall_held", 32'(stall_cycles), 32'h0000FFFF);
    chk("sat_flush", 32'(flush_count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
